// File: rtl/eth_tx_sequencer.sv
// KSZ8851 host transmit sequencer: TXQ space check, QMU DMA frame write, enqueue.
// Optional build macro TX_PAD_EN pads short frames to 60 bytes.
module eth_tx_sequencer #(
  parameter int MAX_FRAME  = 1514,
  parameter int MEM_RETRY  = 8,
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        sendEn,
  input  logic        txStart,
  input  logic [11:0] txLength,
  output logic [9:0]  txAddr,
  input  logic [15:0] txData,
  output logic        txBusy,
  output logic        txDone,
  output logic        txError,
  output logic [7:0]  offset,
  output logic        length,
  output logic        WR,
  output logic [15:0] writeData,
  input  logic [15:0] readData,
  output logic        NewCommand,
  output logic        DMA_Mode,
  input  logic [3:0]  state
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_TXMIR  = 4'd1;
  localparam logic [3:0] S_DIS_INT   = 4'd2;
  localparam logic [3:0] S_RD_RXQCR  = 4'd3;
  localparam logic [3:0] S_SET_SDA   = 4'd4;
  localparam logic [3:0] S_WR_CTRL   = 4'd5;
  localparam logic [3:0] S_WR_COUNT  = 4'd6;
  localparam logic [3:0] S_WR_DATA   = 4'd7;
  localparam logic [3:0] S_RD_RXQCR2 = 4'd8;
  localparam logic [3:0] S_CLR_SDA   = 4'd9;
  localparam logic [3:0] S_SET_METFE = 4'd10;
  localparam logic [3:0] S_POLL      = 4'd11;
  localparam logic [3:0] S_EN_INT    = 4'd12;
  localparam logic [3:0] S_DONE      = 4'd13;
  localparam logic [3:0] S_FAIL      = 4'd14;

  localparam logic [3:0]  BUS_READ2    = 4'd5;
  localparam logic [3:0]  BUS_WRITE0   = 4'd6;
  localparam logic [3:0]  BUS_WRITE2   = 4'd8;
  localparam logic [7:0]  QMU_DATA_OFS = 8'h00;
  localparam logic [11:0] MAX_LEN_C    = 12'(MAX_FRAME);
  localparam logic [8:0]  RETRY_LIM_C  = 9'(MEM_RETRY);
  localparam logic [8:0]  POLL_LIM_C   = 9'(POLL_LIMIT);

  // Frame length rounded up to a dword, expressed in 16-bit words.
  function automatic logic [10:0] word_count(input logic [11:0] n);
    logic [12:0] r;
    r = ({1'b0, n} + 13'd3) & ~13'd3;
    return 11'(r >> 1);
  endfunction

  // TXQ bytes needed: dword-rounded frame plus the 4-byte control/count header.
  function automatic logic [12:0] free_need(input logic [11:0] n);
    logic [12:0] r;
    r = ({1'b0, n} + 13'd3) & ~13'd3;
    return r + 13'd4;
  endfunction

  logic [3:0]  fsm_r;
  logic [11:0] len_r;
  logic [5:0]  fid_r;
  logic [7:0]  retry_r;
  logic [7:0]  poll_r;
  logic [10:0] word_r;
  logic        err_r;

  logic [11:0] len_eff_s;
  logic [10:0] words_s;
  logic [10:0] real_words_s;
  logic [12:0] need_s;
  logic        cmd_done_s;
  logic        pad_word_s;

  // Effective (possibly padded) length and the number of words that come from RAM.
  always_comb begin
`ifdef TX_PAD_EN
    if (len_r < 12'd60) begin
      len_eff_s = 12'd60;
    end else begin
      len_eff_s = len_r;
    end
    real_words_s = 11'(({1'b0, len_r} + 13'd1) >> 1);
`else
    len_eff_s    = len_r;
    real_words_s = word_count(len_r);
`endif
  end

  assign words_s    = word_count(len_eff_s);
  assign need_s     = free_need(len_eff_s);
  assign pad_word_s = (word_r >= real_words_s);

  // Current command completes on the last phase of its read or write cycle.
  always_comb begin
    if (WR) begin
      cmd_done_s = (state == BUS_WRITE2);
    end else begin
      cmd_done_s = (state == BUS_READ2);
    end
  end

  // Sequencer FSM and all registered bus/status outputs; everything freezes without the grant.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      fsm_r      <= S_IDLE;
      len_r      <= 12'd0;
      fid_r      <= 6'd0;
      retry_r    <= 8'd0;
      poll_r     <= 8'd0;
      word_r     <= 11'd0;
      err_r      <= 1'b0;
      offset     <= 8'h00;
      length     <= 1'b1;
      WR         <= 1'b0;
      writeData  <= 16'h0000;
      NewCommand <= 1'b0;
      DMA_Mode   <= 1'b0;
      txAddr     <= 10'd0;
      txBusy     <= 1'b0;
      txDone     <= 1'b0;
      txError    <= 1'b0;
    end else if (sendEn) begin
      length  <= 1'b1;
      txDone  <= 1'b0;
      txError <= 1'b0;
      case (fsm_r)
        S_IDLE: begin
          if (txStart) begin
            len_r   <= txLength;
            txBusy  <= 1'b1;
            retry_r <= 8'd0;
            poll_r  <= 8'd0;
            err_r   <= 1'b0;
            if ((txLength == 12'd0) || (txLength > MAX_LEN_C)) begin
              fsm_r   <= S_FAIL;
              txDone  <= 1'b1;
              txError <= 1'b1;
            end else begin
              fsm_r      <= S_RD_TXMIR;
              offset     <= 8'h78;
              WR         <= 1'b0;
              NewCommand <= 1'b1;
            end
          end
        end
        S_RD_TXMIR: begin
          if (cmd_done_s) begin
            if (readData[12:0] >= need_s) begin
              fsm_r     <= S_DIS_INT;
              offset    <= 8'h90;
              WR        <= 1'b1;
              writeData <= 16'h0000;
            end else if (({1'b0, retry_r} + 9'd1) == RETRY_LIM_C) begin
              fsm_r      <= S_FAIL;
              NewCommand <= 1'b0;
              txDone     <= 1'b1;
              txError    <= 1'b1;
            end else begin
              retry_r <= retry_r + 8'd1;
            end
          end
        end
        S_DIS_INT: begin
          if (cmd_done_s) begin
            fsm_r  <= S_RD_RXQCR;
            offset <= 8'h82;
            WR     <= 1'b0;
          end
        end
        S_RD_RXQCR: begin
          if (cmd_done_s) begin
            fsm_r     <= S_SET_SDA;
            WR        <= 1'b1;
            writeData <= readData | 16'h0008;
          end
        end
        S_SET_SDA: begin
          if (cmd_done_s) begin
            fsm_r     <= S_WR_CTRL;
            DMA_Mode  <= 1'b1;
            txAddr    <= 10'd0;
            offset    <= QMU_DATA_OFS;
            writeData <= {1'b1, 9'd0, fid_r};
          end
        end
        S_WR_CTRL: begin
          if (cmd_done_s) begin
            fsm_r     <= S_WR_COUNT;
            writeData <= {4'h0, len_eff_s};
          end
        end
        S_WR_COUNT: begin
          if (cmd_done_s) begin
            fsm_r  <= S_WR_DATA;
            word_r <= 11'd0;
          end
        end
        S_WR_DATA: begin
          // Padding words are zero and never fetched, so txAddr stops at the last real word.
          if (state == BUS_WRITE0) begin
            writeData <= pad_word_s ? 16'h0000 : txData;
          end
          if (cmd_done_s) begin
            word_r <= word_r + 11'd1;
            if (!pad_word_s) begin
              txAddr <= txAddr + 10'd1;
            end
            if ((word_r + 11'd1) == words_s) begin
              fsm_r    <= S_RD_RXQCR2;
              DMA_Mode <= 1'b0;
              offset   <= 8'h82;
              WR       <= 1'b0;
              fid_r    <= fid_r + 6'd1;
            end
          end
        end
        S_RD_RXQCR2: begin
          if (cmd_done_s) begin
            fsm_r     <= S_CLR_SDA;
            WR        <= 1'b1;
            writeData <= readData & 16'hFFF7;
          end
        end
        S_CLR_SDA: begin
          if (cmd_done_s) begin
            fsm_r     <= S_SET_METFE;
            offset    <= 8'h80;
            writeData <= 16'h0001;
          end
        end
        S_SET_METFE: begin
          if (cmd_done_s) begin
            fsm_r  <= S_POLL;
            WR     <= 1'b0;
            poll_r <= 8'd0;
          end
        end
        S_POLL: begin
          if (cmd_done_s) begin
            if (!readData[0] || (({1'b0, poll_r} + 9'd1) == POLL_LIM_C)) begin
              err_r     <= err_r | readData[0];
              fsm_r     <= S_EN_INT;
              offset    <= 8'h90;
              WR        <= 1'b1;
              writeData <= 16'hEB00;
            end else begin
              poll_r <= poll_r + 8'd1;
            end
          end
        end
        S_EN_INT: begin
          if (cmd_done_s) begin
            fsm_r      <= S_DONE;
            NewCommand <= 1'b0;
            txDone     <= 1'b1;
            txError    <= err_r;
          end
        end
        S_DONE, S_FAIL: begin
          fsm_r  <= S_IDLE;
          txBusy <= 1'b0;
        end
        default: begin
          fsm_r      <= S_IDLE;
          NewCommand <= 1'b0;
          DMA_Mode   <= 1'b0;
          txBusy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Bench for eth_tx_sequencer: bus-controller and frame-RAM models, vector table plus corner sequences.
module tb_eth_tx_sequencer;

  logic        clk40m = 1'b0;
  logic        reset, sendEn, txStart;
  logic [11:0] txLength;
  logic [9:0]  txAddr;
  logic [15:0] txData, readData, writeData;
  logic        txBusy, txDone, txError, length, WR, NewCommand, DMA_Mode;
  logic [7:0]  offset;
  logic [3:0]  bus_state;

  eth_tx_sequencer dut (
    .clk40m(clk40m), .reset(reset), .sendEn(sendEn), .txStart(txStart),
    .txLength(txLength), .txAddr(txAddr), .txData(txData), .txBusy(txBusy),
    .txDone(txDone), .txError(txError), .offset(offset), .length(length),
    .WR(WR), .writeData(writeData), .readData(readData), .NewCommand(NewCommand),
    .DMA_Mode(DMA_Mode), .state(bus_state)
  );

  always #12 clk40m = ~clk40m;

  typedef struct {
    logic        wr;
    logic        dma;
    logic [7:0]  ofs;
    logic [15:0] data;
  } rec_t;

  typedef struct {
    logic [11:0] len;
    logic [15:0] txmir;
    bit          stuck;
    bit          exp_err;
    int          exp_reads;
    int          exp_words;
    logic [15:0] exp_count;
    int          exp_cmds;
  } vec_t;

  rec_t        got_q[$];
  rec_t        exp_q[$];
  vec_t        vecs[$];
  logic [15:0] ram [0:1023];
  logic [15:0] txmir_val, rxqcr_val;
  bit          metfe_stuck;
  int          metfe_left;
  logic [5:0]  exp_fid;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [63:0] RESET_OUTS = {23'd0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0};

  // Bus controller model: Wait -> (Addr0..2 unless DMA) -> Read/Write 0..2 -> Wait.
  always @(posedge clk40m or negedge reset) begin
    if (!reset) bus_state <= 4'd9;
    else if (sendEn) begin
      case (bus_state)
        4'd9: if (NewCommand) bus_state <= DMA_Mode ? (WR ? 4'd6 : 4'd3) : 4'd0;
        4'd0: bus_state <= 4'd1;
        4'd1: bus_state <= 4'd2;
        4'd2: bus_state <= WR ? 4'd6 : 4'd3;
        4'd3: bus_state <= 4'd4;
        4'd4: bus_state <= 4'd5;
        4'd6: bus_state <= 4'd7;
        4'd7: bus_state <= 4'd8;
        default: bus_state <= 4'd9;
      endcase
    end
  end

  always @(posedge clk40m) begin
    if (reset && sendEn && (bus_state == 4'd5 || bus_state == 4'd8)) begin
      got_q.push_back('{WR, DMA_Mode, offset, WR ? writeData : readData});
      if (bus_state == 4'd5 && offset == 8'h80 && metfe_left > 0) metfe_left--;
    end
  end

  always_comb begin
    case (offset)
      8'h78:   readData = txmir_val;
      8'h82:   readData = rxqcr_val;
      8'h80:   readData = (metfe_stuck || metfe_left > 0) ? 16'h0001 : 16'h0000;
      default: readData = 16'hDEAD;
    endcase
  end

  always @(posedge clk40m) txData <= ram[txAddr];

  function automatic logic [63:0] outs_now();
    return {23'd0, offset, length, WR, writeData, NewCommand, DMA_Mode, txAddr, txBusy, txDone, txError};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic build_exp(input vec_t v, input logic [15:0] rx);
    int rw;
    exp_q.delete();
    for (int r = 0; r < v.exp_reads; r++) exp_q.push_back('{1'b0, 1'b0, 8'h78, 16'h0000});
    if (v.exp_words > 0) begin
`ifdef TX_PAD_EN
      rw = (int'(v.len) + 1) / 2;
`else
      rw = v.exp_words;
`endif
      exp_q.push_back('{1'b1, 1'b0, 8'h90, 16'h0000});
      exp_q.push_back('{1'b0, 1'b0, 8'h82, 16'h0000});
      exp_q.push_back('{1'b1, 1'b0, 8'h82, rx | 16'h0008});
      exp_q.push_back('{1'b1, 1'b1, 8'h00, {10'h200, exp_fid}});
      exp_q.push_back('{1'b1, 1'b1, 8'h00, v.exp_count});
      for (int i = 0; i < v.exp_words; i++)
        exp_q.push_back('{1'b1, 1'b1, 8'h00, (i < rw) ? ram[i] : 16'h0000});
      exp_q.push_back('{1'b0, 1'b0, 8'h82, 16'h0000});
      exp_q.push_back('{1'b1, 1'b0, 8'h82, rx & 16'hFFF7});
      exp_q.push_back('{1'b1, 1'b0, 8'h80, 16'h0001});
      for (int p = 0; p < (v.stuck ? 255 : 2); p++) exp_q.push_back('{1'b0, 1'b0, 8'h80, 16'h0000});
      exp_q.push_back('{1'b1, 1'b0, 8'h90, 16'hEB00});
    end
  endtask

  task automatic do_frame(input vec_t v, input int idx, input int restart_at, input int freeze_at);
    int   cyc, reads, hold_bad, bad_at, n;
    bit   done_seen, err_seen;
    logic [63:0] snap;
    logic [15:0] rx;
    got_q.delete();
    rx          = (idx % 2 == 1) ? 16'h063C : 16'h1234;
    rxqcr_val   = rx;
    txmir_val   = v.txmir;
    metfe_stuck = v.stuck;
    metfe_left  = 1;
    build_exp(v, rx);
    @(negedge clk40m); txStart = 1'b1; txLength = v.len;
    @(negedge clk40m); txStart = 1'b0; txLength = 12'h5A5;
    check($sformatf("busy_on[%0d]", idx), 64'(txBusy), 64'd1);
    done_seen = 0; err_seen = 0; cyc = 1;
    while (!done_seen && cyc < 6000) begin
      if (txDone) begin
        done_seen = 1;
        err_seen  = txError;
      end else begin
        txStart = (cyc == restart_at);
        if (cyc == restart_at) txLength = 12'd2;
        if (cyc == freeze_at) begin
          check("freeze_in_data", 64'(DMA_Mode), 64'd1);
          snap = outs_now(); sendEn = 1'b0; hold_bad = 0;
          repeat (20) begin
            @(negedge clk40m);
            if (outs_now() !== snap) hold_bad++;
          end
          check("freeze_hold", 64'(hold_bad), 64'd0);
          sendEn = 1'b1;
        end
        @(negedge clk40m);
        cyc++;
      end
    end
    txStart = 1'b0;
    check($sformatf("done_seen[%0d]", idx), 64'(done_seen), 64'd1);
    check($sformatf("tx_error[%0d]", idx), 64'(err_seen), 64'(v.exp_err));
    if (v.exp_reads == 0) check($sformatf("fail_latency[%0d]", idx), 64'(cyc), 64'd1);
    @(negedge clk40m);
    check($sformatf("done_end[%0d]", idx), 64'({txDone, txBusy}), 64'd0);
    reads = 0;
    foreach (got_q[i]) if (!got_q[i].wr && got_q[i].ofs == 8'h78) reads++;
    check($sformatf("txmir_reads[%0d]", idx), 64'(reads), 64'(v.exp_reads));
    check($sformatf("cmd_count[%0d]", idx), 64'(got_q.size()), 64'(v.exp_cmds));
    bad_at = -1;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n && bad_at < 0; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) bad_at = i;
      else if (got_q[i].wr !== exp_q[i].wr || got_q[i].dma !== exp_q[i].dma ||
               (!exp_q[i].dma && got_q[i].ofs !== exp_q[i].ofs) ||
               (exp_q[i].wr && got_q[i].data !== exp_q[i].data)) bad_at = i;
    end
    n_cmp++;
    if (bad_at >= 0) begin
      n_bad++;
      if (bad_at < got_q.size() && bad_at < exp_q.size())
        $display("FAIL bus_seq[%0d] rec %0d: got wr=%b dma=%b ofs=%h data=%h, expected wr=%b dma=%b ofs=%h data=%h",
                 idx, bad_at, got_q[bad_at].wr, got_q[bad_at].dma, got_q[bad_at].ofs, got_q[bad_at].data,
                 exp_q[bad_at].wr, exp_q[bad_at].dma, exp_q[bad_at].ofs, exp_q[bad_at].data);
      else
        $display("FAIL bus_seq[%0d]: got %0d records, expected %0d", idx, got_q.size(), exp_q.size());
    end
    if (v.exp_words > 0) exp_fid = exp_fid + 6'd1;
    repeat (3) @(negedge clk40m);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 16'h0101 + 16'h1357);
    reset = 1'b0; sendEn = 1'b1; txStart = 1'b0; txLength = 12'd0;
    txmir_val = 16'h0000; rxqcr_val = 16'h0000; metfe_stuck = 0; metfe_left = 0;
    exp_fid = 6'd0;
    repeat (3) @(negedge clk40m);
    check("reset_outputs", outs_now(), RESET_OUTS);
    reset = 1'b1;

    //                len       txmir     stk err rd  W    count     cmds
    vecs.push_back('{12'd64,   16'h1800, 0, 0, 1, 32,  16'h0040, 44});
    vecs.push_back('{12'd61,   16'h0044, 0, 0, 1, 32,  16'h003D, 44});
    vecs.push_back('{12'd61,   16'hE043, 0, 1, 8, 0,   16'h0000, 8});
    vecs.push_back('{12'd100,  16'h0010, 0, 1, 8, 0,   16'h0000, 8});
    vecs.push_back('{12'd0,    16'h1800, 0, 1, 0, 0,   16'h0000, 0});
    vecs.push_back('{12'd1515, 16'h1800, 0, 1, 0, 0,   16'h0000, 0});
    vecs.push_back('{12'd1514, 16'h1FFF, 0, 0, 1, 758, 16'h05EA, 770});
`ifdef TX_PAD_EN
    vecs.push_back('{12'd1,    16'h0008, 0, 1, 8, 0,   16'h0000, 8});
    vecs.push_back('{12'd2,    16'h1800, 1, 1, 1, 30,  16'h003C, 295});
    vecs.push_back('{12'd10,   16'h1800, 0, 0, 1, 30,  16'h003C, 42});
`else
    vecs.push_back('{12'd1,    16'h0008, 0, 0, 1, 2,   16'h0001, 14});
    vecs.push_back('{12'd2,    16'h1800, 1, 1, 1, 2,   16'h0002, 267});
`endif
    for (int i = 0; i < vecs.size(); i++) do_frame(vecs[i], i, -1, -1);

    // Second start mid-frame is ignored; grant dropped for 20 cycles mid data phase.
    do_frame(vecs[0], 100, 10, 100);

    // Start while the grant is low must not be taken.
    got_q.delete();
    @(negedge clk40m); sendEn = 1'b0; txStart = 1'b1; txLength = 12'd64;
    @(negedge clk40m); txStart = 1'b0; sendEn = 1'b1;
    repeat (4) @(negedge clk40m);
    check("start_without_grant", 64'({txBusy, 31'(got_q.size())}), 64'd0);

    // Asynchronous reset mid-frame.
    txmir_val = 16'h1800; metfe_left = 1;
    @(negedge clk40m); txStart = 1'b1; txLength = 12'd64;
    @(negedge clk40m); txStart = 1'b0;
    repeat (60) @(negedge clk40m);
    #3 reset = 1'b0;
    #1 check("reset_mid_frame", outs_now(), RESET_OUTS);
    @(negedge clk40m); reset = 1'b1;
    exp_fid = 6'd0;
    do_frame(vecs[0], 200, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_sequencer.md
Name: eth_tx_sequencer

Overview:
- Host-side transmit sequencer for the KSZ8851 MAC. It is the counterpart of the receive sequencer and drives the same 16-bit register/DMA bus controller.
- On a txStart request it performs the following sequence:
  - checks free TXQ memory (TXMIR);
  - disables interrupts;
  - opens a QMU DMA window (RXQCR.SDA);
  - streams control word, byte count and frame words from a local frame RAM;
  - closes DMA;
  - enqueues the frame (TXQCR.METFE);
  - re-enables interrupts.
- A bus arbiter grants the shared controller through sendEn.

Parameters:
- MAX_FRAME, 1514: largest accepted txLength in bytes.
- MEM_RETRY, 8: number of TXMIR reads before giving up with an error.
- POLL_LIMIT, 255: number of TXQCR reads waiting for METFE to clear before flagging an error.

Ports:
- clk40m  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- sendEn  in  1  arbiter grant; FSM advances only while 1.
- txStart  in  1  one-cycle request pulse; sampled only in IDLE.
- txLength  in  12  frame byte count; captured on txStart.
- txAddr  out  10  word address into the frame RAM; RAM read latency is 1 cycle.
- txData  in  16  frame RAM read data.
- txBusy  out  1  high from accepted start until return to IDLE.
- txDone  out  1  one-cycle pulse at end of sequence.
- txError  out  1  one-cycle pulse coincident with txDone on any failure.
- offset  out  8  register offset to bus controller.
- length  out  1  word access (always 1).
- WR  out  1  1 = write, 0 = read.
- writeData  out  16  write data to bus controller.
- readData  in  16  read data from bus controller.
- NewCommand  out  1  command request to bus controller.
- DMA_Mode  out  1  controller skips Addr phases (QMU data port).
- state  in  4  bus controller phase. Encoding: Addr0=0, Addr1=1, Addr2=2, Read0=3, Read1=4, Read2=5, Write0=6, Write1=7, Write2=8, Wait=9.

Behaviour:
- Reset values: offset=0, length=1, WR=0, writeData=0, NewCommand=0, DMA_Mode=0, txAddr=0, txBusy=0, txDone=0, txError=0; FSM=IDLE; frame ID counter=0.
- Bus handshake:
  - A command is issued by driving offset/WR/writeData with NewCommand=1 while state==Wait.
  - The command completes at state==Read2 (readData valid that cycle) or state==Write2.
  - The FSM moves on at completion. NewCommand is held 1 when a further command follows immediately, and dropped to 0 otherwise.
- sendEn=0: all registers hold (freeze); resume when sendEn returns to 1. Asynchronous reset mid-frame aborts to IDLE with reset values.
- Word count: W = ((len+3) & ~3) >> 1, 11-bit.
- Required free memory: F = ((len+3) & ~3) + 4.
- FSM states, in order:
  - IDLE: on txStart with sendEn=1, latch len and set txBusy=1.
    - If len==0 or len>MAX_FRAME, go to FAIL directly; no bus traffic.
  - RD_TXMIR: read 0x78. If readData[12:0] >= F, go to DIS_INT.
    - Otherwise retry; after MEM_RETRY failed reads, go to FAIL.
  - DIS_INT: write 0x90 = 0x0000.
  - RD_RXQCR: read 0x82 and latch the value.
  - SET_SDA: write 0x82 = latched value | 0x0008. At completion DMA_Mode=1 and txAddr=0.
  - WR_CTRL: write data port = 0x8000 | {10'b0, fid[5:0]}; fid increments after the frame, wrapping 63→0.
  - WR_COUNT: write len zero-extended to 16 bits.
  - WR_DATA: W data writes.
    - writeData is loaded from txData in the state==Write0 cycle.
    - txAddr increments at each Write2.
    - After the W-th Write2, DMA_Mode=0.
  - RD_RXQCR2: read 0x82.
  - CLR_SDA: write 0x82 = value & ~0x0008.
  - SET_METFE: write 0x80 = 0x0001.
  - POLL_METFE: read 0x80 until bit0==0. After POLL_LIMIT reads with bit0 still 1, set a sticky err flag and continue.
  - EN_INT: write 0x90 = 0xEB00.
  - DONE: txDone=1 (and txError=err) for one cycle, then txBusy=0 and return to IDLE.
  - FAIL: txDone=1 and txError=1 for one cycle, then IDLE. Interrupt state is untouched because DIS_INT was never reached.
- txStart while txBusy=1 is ignored. txStart and sendEn=0 in the same cycle is ignored.

Optional Feature:
- TX_PAD_EN defined: frames with len<60 are padded to 60 bytes.
  - Byte count word is 60.
  - W = 30, and F is computed from 60.
  - Words beyond ((len+1)>>1) are written as 0x0000 and are not read from the RAM.
- TX_PAD_EN undefined: length is used as given, no padding.

Test Plan:
- len=64, TXMIR=0x1800 -> write order 0x90←0, 0x82←r|8, 0x8000, 0x0040, 32 data words from txAddr 0..31, 0x82←r&~8, 0x80←1, 0x90←0xEB00; txDone=1, txError=0, fid=1 afterwards.
- len=61 -> W=32 words (padded to 64 bytes), byte count word 0x003D, F=68 checked against TXMIR.
- TXMIR=0x0010 on all reads, len=100 -> exactly 8 TXMIR reads, no write to 0x90; txDone and txError pulse together.
- len=0 or len=1515 -> zero bus commands; txError pulse within 2 cycles.
- TXQCR bit0 stuck at 1 -> 255 polls, then 0x90←0xEB00 still written; txError=1.
- sendEn=0 for 20 cycles mid WR_DATA -> outputs frozen, frame completes intact; separately, reset asserted mid-frame -> all outputs return to reset values asynchronously.
- TX_PAD_EN build, len=10 -> byte count 60, 5 RAM words then 25 zero words.
